// File: rtl/sudoku_controller_pkg.sv
// Shared constants and types for the gamepad event path feeding the sudoku game logic.
package sudoku_controller_pkg;

  localparam int NUM_BUTTONS = 12;

  localparam int BTN_UP    = 11;
  localparam int BTN_DOWN  = 10;
  localparam int BTN_LEFT  = 9;
  localparam int BTN_RIGHT = 8;
  localparam int BTN_A     = 7;
  localparam int BTN_B     = 6;
  localparam int BTN_C     = 5;
  localparam int BTN_X     = 4;
  localparam int BTN_Y     = 3;
  localparam int BTN_Z     = 2;
  localparam int BTN_START = 1;
  localparam int BTN_MODE  = 0;

  localparam logic [NUM_BUTTONS-1:0] DIR_MASK = 12'hF00;

  localparam int EVENT_CODE_W     = 4;
  localparam int EVENT_FIFO_DEPTH = 4;

  typedef logic [EVENT_CODE_W-1:0] event_code_t;

  // Index of the most significant set bit; 0 when the vector is empty.
  function automatic event_code_t highest_set(input logic [NUM_BUTTONS-1:0] vec);
    event_code_t idx;
    idx = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (vec[i]) idx = event_code_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous show-ahead FIFO holding button event codes.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  // Empty FIFO presents a zero code rather than a stale entry.
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/controller_events.sv
// Debounces the raw gamepad vector, detects presses, auto-repeats the D-pad and
// queues button events for the game logic, back-pressuring the reader when full.
module controller_events
  import sudoku_controller_pkg::*;
#(
  parameter int SAMPLE_DIV       = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_DELAY     = 400,
  parameter int REPEAT_RATE      = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] buttons,
  output logic [11:0] held,
  output logic        event_valid,
  output logic [3:0]  event_code,
  input  logic        event_ready,
  output logic        block
);

  localparam int TICK_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DB_W       = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int RPT_W      = $clog2(REPEAT_DELAY + 1);
  localparam int FIFO_CNT_W = $clog2(EVENT_FIFO_DEPTH + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]  RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [TICK_W-1:0]      tick_cnt;
  logic                   tick;
  logic [DB_W-1:0]        db_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] stable_d;
  logic [NUM_BUTTONS-1:0] press_rise;
  logic [NUM_BUTTONS-1:0] dir_now;
  logic [NUM_BUTTONS-1:0] dir_prev;
  logic [RPT_W-1:0]       rpt_cnt;
  logic [RPT_W-1:0]       rpt_next;
  logic                   rpt_fire;
  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] pending_next;
  logic                   push;
  event_code_t            push_code;
  event_code_t            fifo_head;
  logic [FIFO_CNT_W-1:0]  fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Per-bit debounce: a bit flips only after DEBOUNCE_SAMPLES consecutive disagreeing ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
      stable <= '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (buttons[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= buttons[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign press_rise = stable & ~stable_d;
  assign dir_now    = stable & DIR_MASK;
  assign dir_prev   = stable_d & DIR_MASK;

  // Repeat timer restarts whenever the D-pad combination changes or is released.
  always_comb begin
    rpt_next = rpt_cnt;
    rpt_fire = 1'b0;
    if ((dir_now != dir_prev) || (dir_now == '0)) begin
      rpt_next = '0;
    end else if (tick) begin
      if (rpt_cnt == RPT_LAST) begin
        rpt_fire = 1'b1;
        rpt_next = RPT_RELOAD;
      end else begin
        rpt_next = rpt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_next;
    end
  end

  // Push decision uses the FIFO count from the start of the cycle.
  assign push      = (pending != '0) && !fifo_full;
  assign push_code = highest_set(pending);

  always_comb begin
    pending_next = pending;
    if (push) pending_next[push_code] = 1'b0;
    pending_next = pending_next | press_rise;
    if (rpt_fire) pending_next = pending_next | dir_now;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign pop = event_valid && event_ready;

  event_fifo #(
    .DEPTH (EVENT_FIFO_DEPTH),
    .WIDTH (EVENT_CODE_W)
  ) u_event_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_code),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign held        = stable;
  assign event_valid = !fifo_empty;
  assign event_code  = fifo_head;
  assign block       = (fifo_count == FIFO_CNT_W'(EVENT_FIFO_DEPTH));

endmodule

// File: tb/tb_controller_events.sv
// Scoreboard bench for controller_events with shortened tick/debounce/repeat timing.
module tb_controller_events;
  import sudoku_controller_pkg::*;

  localparam int SAMPLE_DIV       = 4;
  localparam int DEBOUNCE_SAMPLES = 3;
  localparam int REPEAT_DELAY     = 5;
  localparam int REPEAT_RATE      = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] buttons = '0;
  logic [11:0] held;
  logic        event_valid;
  logic [3:0]  event_code;
  logic        event_ready = 1'b0;
  logic        block;

  controller_events #(
    .SAMPLE_DIV       (SAMPLE_DIV),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
    .REPEAT_DELAY     (REPEAT_DELAY),
    .REPEAT_RATE      (REPEAT_RATE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons     (buttons),
    .held        (held),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_ready (event_ready),
    .block       (block)
  );

  always #5 clk = ~clk;

  // Count of clock edges since reset released; tick edges are the multiples of SAMPLE_DIV.
  int k;
  always @(posedge clk) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  typedef struct {
    int code;
    int exp_k;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input int code, input int exp_k);
    exp_t e;
    e.code  = code;
    e.exp_k = exp_k;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_held(input logic [11:0] val, input int budget, output int at_k);
    at_k = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (held == val) begin
        at_k = k;
        break;
      end
    end
    if (at_k < 0) check_eq("held_timeout", 32'(held), 32'(val));
  endtask

  // Edge at which a raw change driven just after edge k0 lands in stable.
  function automatic int db_edge(input int k0);
    return ((k0 / SAMPLE_DIV) + 1) * SAMPLE_DIV + (DEBOUNCE_SAMPLES - 1) * SAMPLE_DIV;
  endfunction

  exp_t got;
  always @(negedge clk) begin
    if (!reset && event_valid && event_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_event", 32'(event_code), 32'd16);
      end else begin
        got = sb.pop_front();
        check_eq("event_code", 32'(event_code), got.code);
        if (got.exp_k >= 0) check_eq("event_cycle", k, got.exp_k);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, e, er, at, seen;

    step(3);
    @(negedge clk);
    check_eq("rst_held", 32'(held), 0);
    check_eq("rst_valid", 32'(event_valid), 0);
    check_eq("rst_code", 32'(event_code), 0);
    check_eq("rst_block", 32'(block), 0);
    step(1);
    reset = 1'b0;
    step(2);

    // Single press of a
    event_ready = 1'b1;
    k0 = k;
    buttons = 12'h080;
    e = db_edge(k0);
    expect_evt(BTN_A, e + 2);
    wait_held(12'h080, 40, at);
    check_eq("press_a_edge", at, e);
    @(negedge clk);
    check_eq("press_a_valid_e1", 32'(event_valid), 0);
    step(40);
    buttons = '0;
    wait_held(12'h000, 40, at);
    step(8);

    // Glitch of two ticks must not propagate
    seen = 0;
    buttons = 12'h001;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 7) buttons = '0;
      if (held != '0) seen++;
    end
    check_eq("glitch_held", seen, 0);

    // Simultaneous up/start/mode with back-pressure
    event_ready = 1'b0;
    k0 = k;
    buttons = 12'h803;
    e = db_edge(k0);
    expect_evt(BTN_UP, -1);
    expect_evt(BTN_START, -1);
    expect_evt(BTN_MODE, -1);
    wait_held(12'h803, 40, at);
    check_eq("multi_edge", at, e);
    check_eq("multi_valid_e0", 32'(event_valid), 0);
    @(negedge clk);
    check_eq("multi_valid_e1", 32'(event_valid), 0);
    @(negedge clk);
    check_eq("multi_valid_e2", 32'(event_valid), 1);
    check_eq("multi_head_e2", 32'(event_code), BTN_UP);
    @(negedge clk);
    @(negedge clk);
    check_eq("multi_block", 32'(block), 0);
    step(1);
    event_ready = 1'b1;
    buttons = '0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check_eq("multi_drained", 32'(event_valid), 0);
    wait_held(12'h000, 40, at);
    step(8);

    // D-pad auto-repeat
    event_ready = 1'b1;
    k0 = k;
    buttons = 12'h800;
    e  = db_edge(k0);
    er = db_edge(k0 + 80);
    expect_evt(BTN_UP, e + 2);
    for (int t = e + REPEAT_DELAY * SAMPLE_DIV; t <= er; t += REPEAT_RATE * SAMPLE_DIV)
      expect_evt(BTN_UP, t + 1);
    step(80);
    buttons = '0;
    wait_held(12'h000, 40, at);
    check_eq("repeat_release_edge", at, er);
    step(8);

    // Full FIFO: five simultaneous presses, one stays pending
    event_ready = 1'b0;
    k0 = k;
    buttons = 12'h0F8;
    e = db_edge(k0);
    for (int b = BTN_A; b >= BTN_Y; b--) expect_evt(b, -1);
    wait_held(12'h0F8, 40, at);
    repeat (4) @(negedge clk);
    check_eq("full_block_e4", 32'(block), 0);
    @(negedge clk);
    check_eq("full_block_e5", 32'(block), 1);
    repeat (3) @(negedge clk);
    check_eq("full_block_hold", 32'(block), 1);
    step(1);
    event_ready = 1'b1;
    step(1);
    event_ready = 1'b0;
    @(negedge clk);
    check_eq("full_block_after_pop", 32'(block), 0);
    @(negedge clk);
    check_eq("full_block_refill", 32'(block), 1);
    step(1);
    event_ready = 1'b1;
    buttons = '0;
    wait_held(12'h000, 40, at);
    step(8);
    check_eq("full_drained", 32'(event_valid), 0);

    // Reset with two entries queued and one bit pending
    event_ready = 1'b0;
    k0 = k;
    buttons = 12'h0E0;
    wait_held(12'h0E0, 40, at);
    repeat (3) @(negedge clk);
    check_eq("rst_mid_valid_before", 32'(event_valid), 1);
    reset = 1'b1;
    buttons = '0;
    @(negedge clk);
    check_eq("rst_mid_valid", 32'(event_valid), 0);
    check_eq("rst_mid_held", 32'(held), 0);
    check_eq("rst_mid_block", 32'(block), 0);
    check_eq("rst_mid_code", 32'(event_code), 0);
    step(1);
    reset = 1'b0;
    event_ready = 1'b1;
    step(40);
    check_eq("rst_no_stale", 32'(event_valid), 0);

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_events.md
# controller_events

Converts the raw 12-bit held-button vector from the gamepad reader into a debounced held vector and a queue of discrete button events for the sudoku game logic. It debounces each button, emits one event per press, and auto-repeats the D-pad. Events are buffered in a 4-entry FIFO drained by a valid/ready handshake. When the FIFO is full, the block asserts `block` back to the reader, which halts polling.

## Interface
- `SAMPLE_DIV`, 50000: clocks per sample tick (1 ms at 50 MHz).
- `DEBOUNCE_SAMPLES`, 4: consecutive disagreeing ticks before a bit changes state.
- `REPEAT_DELAY`, 400: ticks a direction is held before the first repeat.
- `REPEAT_RATE`, 100: ticks between subsequent repeats.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `buttons` in 12: raw held vector from the reader, 1 = pressed. Bit mapping: 11 up, 10 down, 9 left, 8 right, 7 a, 6 b, 5 c, 4 x, 3 y, 2 z, 1 start, 0 mode.
- `held` out 12: debounced held vector, same bit mapping.
- `event_valid` out 1: FIFO head is valid.
- `event_code` out 4: event code at the FIFO head. Code = button bit index 0..11; codes 12..15 are never produced.
- `event_ready` in 1: consumer accepts the head.
- `block` out 1: high while the FIFO holds 4 entries; drives the reader's `block` input.

## Operation
- **Tick.** A tick counter runs 0..SAMPLE_DIV-1. `tick` is high in the cycle the counter equals SAMPLE_DIV-1, then the counter wraps to 0.
- **Debounce, per bit, on tick only.**
  - If raw ≠ stable: increment cnt[i].
  - When cnt[i] reaches DEBOUNCE_SAMPLES: stable[i] ← raw[i] and cnt[i] ← 0.
  - If raw = stable: cnt[i] ← 0.
  - `held` = stable.
- **Press detect.** Every cycle, a rising edge on stable[i] (stable & ~stable_d) ORs bit i into the `pending` mask.
- **Auto-repeat (bits 11..8 only).**
  - The repeat counter clears to 0 whenever stable[11:8] differs from its previous value, or is all zero.
  - Otherwise it increments on each tick.
  - On the tick where it reaches REPEAT_DELAY, OR stable[11:8] into pending. Then reload the counter to REPEAT_DELAY-REPEAT_RATE so a repeat fires every REPEAT_RATE ticks.
- **Push.**
  - Each cycle, if pending ≠ 0 and the FIFO is not full: push the highest set index and clear that pending bit.
  - Push is at most one event per cycle.
  - A press while its bit is already pending merges into that bit and is not counted twice.
  - Pending bits are never dropped while the FIFO is full.
- **Pop.** The head pops when event_valid && event_ready.
  - Push is decided on the count at the start of the cycle, so when full, a simultaneous pop does not enable a push that cycle.
  - When not full, push and pop in the same cycle leave the count unchanged.
- **Reset values** (reset may occur mid-operation; it clears everything): held 0, event_valid 0, event_code 0, block 0. Tick counter, all cnt[i], stable, stable_d, pending, repeat counter and FIFO pointers/count are 0.

## Timing
- Tick-domain latency: a raw change held for DEBOUNCE_SAMPLES ticks updates stable at the clock edge of the DEBOUNCE_SAMPLES-th tick (edge E).
- Pending bit is set at E+1.
- Push happens at E+2, provided the FIFO is not full and no higher-index bit is pending; event_valid is high from E+2.
- event_code is the head entry and stays stable while event_valid && !event_ready.
- `block` rises the cycle after the 4th entry is pushed and falls the cycle after a pop from full.
- Glitch rule: a raw pulse shorter than DEBOUNCE_SAMPLES ticks produces no `held` change and no event.
- Release: a release produces no event; `held` clears after debounce.

## Structure
- Package `sudoku_controller_pkg` holds:
  - button index constants BTN_UP=11 … BTN_MODE=0;
  - DIR_MASK = 12'hF00;
  - `event_code_t` (4-bit).
- Sub-module `event_fifo`: 4 entries × 4 bits, synchronous, with count, full/empty, and show-ahead head output.
- The rest is flat in controller_events: tick counter, debounce array, pending mask, repeat counter, priority encoder.

## Test plan
Bench parameters: SAMPLE_DIV=4, DEBOUNCE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2.

- **Press a.** buttons=12'h080 held for 40 cycles, event_ready=1 → held=12'h080 at the 3rd tick edge; exactly one event with code 7, event_valid high from edge+2.
- **Glitch rejection.** buttons=12'h001 for 8 cycles (2 ticks), then 0 → held stays 0; no event.
- **Simultaneous press and back-pressure.** buttons=12'h803 (up, start, mode) with event_ready=0 → FIFO receives 11, 1, 0 in that order on consecutive cycles; block stays 0.
- **Auto-repeat.** Hold up (12'h800) for 80 cycles with event_ready=1 → codes 11 at debounce, then at 5 ticks after debounce, then every 2 ticks; no repeats for a held a-button.
- **Full FIFO.** event_ready=0, then press five distinct buttons → block=1 after the 4th push; the 5th stays pending; one pop → block drops, and the 5th is pushed the following cycle.
- **Reset mid-operation.** Assert reset with the FIFO at 2 entries and a bit pending → next cycle event_valid=0, held=0, block=0; after release, no stale event appears.
